pc_fetch_sequencer: RTL
=======================

PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have exactly one clock and one reset: CLK and Reset_L. Reset_L is synchronous and active-low; the polarity and synchronicity are fixed.
REQ-003 Port list (name direction width meaning):
- CLK  in  1  rising-edge clock
- Reset_L  in  1  synchronous active-low reset
- StartPC  in  64  PC loaded on reset
- BusImm  in  64  branch offset from the sign extender, already sign-extended and shifted left 2
- Branch  in  1  conditional branch (CBZ) resolved this cycle
- Uncondbranch  in  1  unconditional branch (B)
- ALUZero  in  1  ALU zero flag for the conditional branch
- ExecValid  in  1  Branch, Uncondbranch, ALUZero and BusImm are valid
- IReqValid  out  1  instruction memory read request
- IReqAddr  out  64  instruction memory read address
- IRespValid  in  1  instruction memory read data valid
- IRespData  in  32  instruction word
- InstrValid  out  1  Instr and InstrPC hold a fetched instruction
- InstrReady  in  1  downstream decode accepts Instr
- Instr  out  32  fetched instruction
- InstrPC  out  64  address of Instr
- CurrentPC  out  64  architectural PC register
- InstrCount  out  32  count of instructions accepted downstream

Function
REQ-004 The FSM SHALL have five states: IDLE, FETCH, WAIT, ISSUE, RESOLVE.
REQ-005 IDLE SHALL go to FETCH on the next edge with Reset_L=1.
REQ-006 FETCH SHALL drive IReqValid=1 and IReqAddr=CurrentPC for exactly one cycle, then go to WAIT. IReqValid SHALL be 0 in every other state.
REQ-007 On an edge in WAIT with IRespValid=1, the block SHALL latch Instr<=IRespData and InstrPC<=CurrentPC, then go to ISSUE. With IRespValid=0 it SHALL stay in WAIT, with no timeout.
REQ-008 IRespValid SHALL be ignored in all states except WAIT.
REQ-009 InstrValid SHALL be 1 only in ISSUE. Instr and InstrPC SHALL hold stable while InstrValid=1 and InstrReady=0.
REQ-010 On an edge in ISSUE with InstrReady=1, the block SHALL increment InstrCount by 1 and go to RESOLVE.
REQ-011 On an edge in RESOLVE with ExecValid=1:
- CurrentPC <= taken ? CurrentPC+BusImm : CurrentPC+4
- taken = Uncondbranch OR (Branch AND ALUZero)
- then go to FETCH
With ExecValid=0 the block SHALL stay in RESOLVE.
REQ-012 ExecValid and the branch inputs SHALL be ignored outside RESOLVE.
REQ-013 Uncondbranch=1 together with Branch=1 SHALL be treated as taken.
REQ-014 PC arithmetic SHALL be 64-bit modulo 2^64. BusImm is two's complement, so negative offsets move the PC backward. Carry out SHALL be discarded, and no alignment check SHALL be applied.
REQ-015 InstrCount SHALL wrap from 0xFFFFFFFF to 0x00000000.
REQ-016 Latency: one instruction SHALL take at least 4 cycles, edge-to-edge from FETCH entry back to FETCH entry (FETCH, WAIT, ISSUE, RESOLVE), with zero-wait responses, ready and exec.
REQ-017 IReqAddr SHALL equal CurrentPC combinationally in all states.

Reset
REQ-018 On any edge with Reset_L=0, in any state, the block SHALL set:
- state = IDLE
- CurrentPC = StartPC
- Instr = 0, InstrPC = 0, InstrCount = 0
- IReqValid = 0, InstrValid = 0
REQ-019 Reset SHALL take priority over every other input in the same cycle.
REQ-020 After reset, a response still outstanding from a pre-reset request SHALL be discarded. This follows from REQ-008, because the state is not WAIT.
REQ-021 StartPC SHALL be sampled only while Reset_L=0.

Verification
REQ-022 Sequential fetch:
- stimulus: StartPC=0x1000; zero-wait memory returning 0xAAAA0001; InstrReady=1; ExecValid=1 with no branch
- response: IReqAddr sequence 0x1000, 0x1004, 0x1008; InstrCount=3 after 12 cycles from the first FETCH
REQ-023 Backward unconditional branch:
- stimulus: PC=0x2000, Uncondbranch=1, BusImm=0xFFFFFFFFFFFFFFF8
- response: next IReqAddr=0x1FF8
REQ-024 Conditional branch, both flag values:
- Branch=1, ALUZero=0, BusImm=0x40, PC=0x3000: next PC=0x3004
- same with ALUZero=1: next PC=0x3040
REQ-025 Backpressure and stalls:
- InstrReady held 0 for 5 cycles: InstrValid stays 1 and Instr stays constant; InstrCount increments once, only at the accepting edge
- IRespValid pulsed during RESOLVE: no state change
REQ-026 Reset mid-operation and wrap-around:
- Reset_L=0 for one cycle while in WAIT, StartPC=0x500, then a stray IRespValid: state=IDLE, CurrentPC=0x500, stray response ignored, next IReqAddr=0x500
- PC=0xFFFFFFFFFFFFFFFC with not-taken: next PC=0x0

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch sequencer bus: instruction-memory request/response, decode handoff and
// execute-stage branch resolution, plus the architectural PC/count observers.
interface pc_fetch_sequencer_if;
   logic [63:0] StartPC;
   logic [63:0] BusImm;
   logic        Branch;
   logic        Uncondbranch;
   logic        ALUZero;
   logic        ExecValid;
   logic        IReqValid;
   logic [63:0] IReqAddr;
   logic        IRespValid;
   logic [31:0] IRespData;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] Instr;
   logic [63:0] InstrPC;
   logic [63:0] CurrentPC;
   logic [31:0] InstrCount;

   modport master (
      input  StartPC, BusImm, Branch, Uncondbranch, ALUZero, ExecValid,
             IRespValid, IRespData, InstrReady,
      output IReqValid, IReqAddr, InstrValid, Instr, InstrPC, CurrentPC, InstrCount
   );

   modport slave (
      output StartPC, BusImm, Branch, Uncondbranch, ALUZero, ExecValid,
             IRespValid, IRespData, InstrReady,
      input  IReqValid, IReqAddr, InstrValid, Instr, InstrPC, CurrentPC, InstrCount
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Single-issue fetch sequencer: requests one instruction, hands it to decode,
// then waits for execute to resolve the next PC before fetching again.
module pc_fetch_sequencer (
   input logic                  CLK,
   input logic                  Reset_L,
   pc_fetch_sequencer_if.master bus
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FETCH   = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] ISSUE   = 3'd3;
   localparam logic [2:0] RESOLVE = 3'd4;

   logic [2:0]  state;
   logic [2:0]  state_next;
   logic [63:0] current_pc;
   logic [63:0] instr_pc;
   logic [31:0] instr;
   logic [31:0] instr_count;
   logic        taken;
   logic [63:0] pc_step;
   logic [63:0] next_pc;

   // A B overrides CBZ, so Uncondbranch alone is enough to redirect.
   always_comb begin
      taken   = bus.Uncondbranch | (bus.Branch & bus.ALUZero);
      pc_step = taken ? bus.BusImm : 64'd4;
      next_pc = current_pc + pc_step;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = FETCH;
         FETCH:   state_next = WAIT;
         WAIT:    if (bus.IRespValid) state_next = ISSUE;
         ISSUE:   if (bus.InstrReady) state_next = RESOLVE;
         RESOLVE: if (bus.ExecValid)  state_next = FETCH;
         default: state_next = IDLE;
      endcase
   end

   // Responses and branch results only land in their own state, which also
   // drops any response left over from a request issued before reset.
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         state       <= IDLE;
         current_pc  <= bus.StartPC;
         instr       <= 32'd0;
         instr_pc    <= 64'd0;
         instr_count <= 32'd0;
      end else begin
         state <= state_next;
         if (state == WAIT && bus.IRespValid) begin
            instr    <= bus.IRespData;
            instr_pc <= current_pc;
         end
         if (state == ISSUE && bus.InstrReady)
            instr_count <= instr_count + 32'd1;
         if (state == RESOLVE && bus.ExecValid)
            current_pc <= next_pc;
      end
   end

   assign bus.IReqValid  = (state == FETCH);
   assign bus.IReqAddr   = current_pc;
   assign bus.InstrValid = (state == ISSUE);
   assign bus.Instr      = instr;
   assign bus.InstrPC    = instr_pc;
   assign bus.CurrentPC  = current_pc;
   assign bus.InstrCount = instr_count;

endmodule
